// File: rtl/reqgnt_responder.sv
// reqgnt_responder: grant side of a req/gnt handshake.
// Arbitrates N requesters round-robin. After a fixed service delay it returns a one-cycle
// gnt pulse to the winner. It flags a requester that drops req before receiving its gnt.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high
//   i_req[N]     request vector; a request is held until its gnt
//   o_gnt[N]     one-hot-or-zero grant pulse (registered)
//   o_busy       high while a grant is in progress (WAIT or GRANT)
//   o_winner_id  index of the current winner; valid while o_busy=1
//   o_err_drop   sticky flag: a winner's req fell before its gnt; cleared only by reset
module reqgnt_responder #(
  parameter int unsigned N     = 4,
  parameter int unsigned DELAY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic                 o_busy,
  output logic [$clog2(N)-1:0] o_winner_id,
  output logic                 o_err_drop
);

  localparam int unsigned IdW = $clog2(N);
  localparam logic [IdW:0] NumReq = (IdW+1)'(N);
  localparam logic [N-1:0] One = N'(1);
  localparam logic [3:0] CntInit = (DELAY == 0) ? 4'd0 : 4'(DELAY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StGrant} state_e;

  state_e         r_state;
  logic [IdW-1:0] r_ptr;
  logic [IdW-1:0] r_winner;
  logic [3:0]     r_cnt;
  logic [N-1:0]   r_gnt;
  logic           r_busy;
  logic           r_err;

  logic           w_found;
  logic [IdW-1:0] w_pick;
  logic [IdW-1:0] w_ptr_next;

  // Round-robin scan starting at r_ptr. The sum is one bit wider so the wrap back to 0
  // is exact even when N is not a power of two.
  always_comb begin
    logic [IdW:0] w_sum;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IdW+1)'(k);
      if (w_sum >= NumReq) begin
        w_sum = w_sum - NumReq;
      end
      if (!w_found && i_req[w_sum[IdW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IdW-1:0];
      end
    end
  end

  assign w_ptr_next = (r_winner == IdW'(N - 1)) ? '0 : r_winner + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_winner <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_winner <= w_pick;
            r_busy   <= 1'b1;
            if (DELAY == 0) begin
              r_state <= StGrant;
              r_gnt   <= One << w_pick;
            end else begin
              r_state <= StWait;
              r_cnt   <= CntInit;
            end
          end
        end
        StWait: begin
          if (!i_req[r_winner]) begin
            // Winner withdrew early: abort without a grant.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (r_cnt == 4'd0) begin
            r_state <= StGrant;
            r_gnt   <= One << r_winner;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StGrant: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_busy      = r_busy;
  assign o_winner_id = r_winner;
  assign o_err_drop  = r_err;

endmodule

// File: tb/tb_reqgnt_responder.sv
// Bench for reqgnt_responder. It drives two instances (DELAY=2 and DELAY=0) side by side.
// A transaction-level reference model predicts every output cycle by cycle.
module tb_reqgnt_responder;
  localparam int N  = 4;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] gnt_a, gnt_b;
  logic busy_a, busy_b, err_a, err_b;
  logic [1:0] win_a, win_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int p_raise = 30;
  int p_drop  = 0;

  always #5 clk = ~clk;

  reqgnt_responder #(.N(N), .DELAY(2)) u_dut_d2 (
    .i_clk(clk), .i_rst(rst), .i_req(req_a), .o_gnt(gnt_a), .o_busy(busy_a),
    .o_winner_id(win_a), .o_err_drop(err_a)
  );

  reqgnt_responder #(.N(N), .DELAY(0)) u_dut_d0 (
    .i_clk(clk), .i_rst(rst), .i_req(req_b), .o_gnt(gnt_b), .o_busy(busy_b),
    .o_winner_id(win_b), .o_err_drop(err_b)
  );

  // Model: each transaction is described by its arbitration cycle, its grant cycle and
  // the last cycle in which busy is high. A cycle is free for arbitration once the
  // previous transaction's last busy cycle has passed.
  int dly [NI] = '{2, 0};
  int m_arb [NI], m_grant [NI], m_last [NI], m_ptr [NI], m_win [NI];
  bit m_abort [NI], m_err [NI];
  bit want [NI][N];
  bit cool [NI][N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_gnt(input int k);
    if (cyc == m_grant[k] && !m_abort[k]) return N'(1) << m_win[k];
    return '0;
  endfunction

  function automatic bit exp_busy(input int k);
    return (cyc > m_arb[k]) && (cyc <= m_last[k]);
  endfunction

  // Called at a falling edge: check the current cycle, drive this cycle's inputs,
  // advance the model, then move to the next falling edge.
  task automatic do_cycle(input bit rst_v, input bit frc, input logic [N-1:0] f0,
                          input logic [N-1:0] f1, input bit chk);
    logic [N-1:0] obs_g [NI];
    logic         obs_b [NI];
    logic         obs_e [NI];
    logic [1:0]   obs_w [NI];
    logic [N-1:0] r [NI];
    logic [N-1:0] eg;
    int w;
    obs_g = '{gnt_a, gnt_b};
    obs_b = '{busy_a, busy_b};
    obs_e = '{err_a, err_b};
    obs_w = '{win_a, win_b};
    for (int k = 0; k < NI; k++) begin
      eg = exp_gnt(k);
      if (chk) begin
        check_eq($sformatf("gnt%0d", k), 32'(obs_g[k]), 32'(eg));
        check_eq($sformatf("busy%0d", k), 32'(obs_b[k]), 32'(exp_busy(k)));
        check_eq($sformatf("err%0d", k), 32'(obs_e[k]), 32'(m_err[k]));
        if (exp_busy(k)) check_eq($sformatf("winner%0d", k), 32'(obs_w[k]), 32'(m_win[k]));
        check_eq($sformatf("onehot%0d", k), 32'($onehot0(obs_g[k])), 32'd1);
        check_eq($sformatf("idle_gnt%0d", k), 32'(!obs_b[k] && obs_g[k] != '0), 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (frc) begin
          r[k][i]    = (k == 0) ? f0[i] : f1[i];
          want[k][i] = r[k][i];
          cool[k][i] = 1'b0;
        end else if (cool[k][i]) begin
          r[k][i]    = 1'b0;
          cool[k][i] = 1'b0;
          want[k][i] = 1'b0;
        end else if (eg[i]) begin
          r[k][i]    = 1'b1;
          cool[k][i] = 1'b1;
        end else if (want[k][i]) begin
          if (int'($urandom_range(999)) < p_drop) want[k][i] = 1'b0;
          r[k][i] = want[k][i];
        end else begin
          want[k][i] = int'($urandom_range(99)) < p_raise;
          r[k][i]    = want[k][i];
        end
      end
    end
    rst   = rst_v;
    req_a = r[0];
    req_b = r[1];
    for (int k = 0; k < NI; k++) begin
      if (rst_v) begin
        m_abort[k] = 1'b1;
        m_last[k]  = cyc;
        m_arb[k]   = cyc;
        m_ptr[k]   = 0;
        m_err[k]   = 1'b0;
        m_win[k]   = 0;
        for (int i = 0; i < N; i++) cool[k][i] = 1'b0;
      end else if (cyc > m_last[k]) begin
        if (r[k] != '0) begin
          w = m_ptr[k];
          while (!r[k][w]) w = (w + 1) % N;
          m_win[k]   = w;
          m_arb[k]   = cyc;
          m_grant[k] = cyc + 1 + dly[k];
          m_last[k]  = m_grant[k];
          m_abort[k] = 1'b0;
        end
      end else if (!m_abort[k] && cyc < m_grant[k] && !r[k][m_win[k]]) begin
        m_err[k]   = 1'b1;
        m_abort[k] = 1'b1;
        m_last[k]  = cyc;
      end else if (!m_abort[k] && cyc == m_grant[k]) begin
        m_ptr[k] = (m_win[k] + 1) % N;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  int g_idx [$];
  int g_cyc [$];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_arb[k] = -100; m_grant[k] = -100; m_last[k] = -100;
      m_ptr[k] = 0; m_win[k] = 0; m_abort[k] = 1'b1; m_err[k] = 1'b0;
      for (int i = 0; i < N; i++) begin want[k][i] = 1'b0; cool[k][i] = 1'b0; end
    end
    do_cycle(1'b1, 1'b1, '0, '0, 1'b0);
    check_eq("rst_gnt", 32'(gnt_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_winner", 32'(win_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);

    // Single request, DELAY=2: gnt three cycles after arbitration.
    do_cycle(1'b0, 1'b1, 4'b0001, '0, 1'b1);
    check_eq("t1_busy_c1", 32'(busy_a), 32'd1);
    check_eq("t1_gnt_c1", 32'(gnt_a), 32'd0);
    do_cycle(1'b0, 1'b1, 4'b0001, '0, 1'b1);
    check_eq("t1_gnt_c2", 32'(gnt_a), 32'd0);
    do_cycle(1'b0, 1'b1, 4'b0001, '0, 1'b1);
    check_eq("t1_gnt_c3", 32'(gnt_a), 32'b0001);
    check_eq("t1_busy_c3", 32'(busy_a), 32'd1);
    do_cycle(1'b0, 1'b1, 4'b0001, '0, 1'b1);
    check_eq("t1_gnt_c4", 32'(gnt_a), 32'd0);
    check_eq("t1_busy_c4", 32'(busy_a), 32'd0);
    do_cycle(1'b0, 1'b1, '0, '0, 1'b1);

    // Reset during WAIT (ptr is 1 beforehand): no late grant, ptr back to 0.
    do_cycle(1'b0, 1'b1, 4'b0001, '0, 1'b1);
    do_cycle(1'b1, 1'b1, 4'b0001, '0, 1'b1);
    check_eq("t5_gnt", 32'(gnt_a), 32'd0);
    check_eq("t5_busy", 32'(busy_a), 32'd0);
    check_eq("t5_err", 32'(err_a), 32'd0);
    for (int j = 0; j < 4; j++) begin
      do_cycle(1'b0, 1'b1, '0, '0, 1'b1);
      check_eq("t5_no_late_gnt", 32'(gnt_a), 32'd0);
    end
    do_cycle(1'b0, 1'b1, 4'b1001, '0, 1'b1);
    check_eq("t5_ptr0_winner", 32'(win_a), 32'd0);
    do_cycle(1'b0, 1'b1, 4'b1001, '0, 1'b1);
    do_cycle(1'b0, 1'b1, 4'b1001, '0, 1'b1);
    check_eq("t5_gnt_after", 32'(gnt_a), 32'b0001);
    do_cycle(1'b0, 1'b1, 4'b1001, '0, 1'b1);
    do_cycle(1'b0, 1'b1, '0, '0, 1'b1);

    // Winner drops in its first WAIT cycle: abort and sticky err_drop.
    do_cycle(1'b0, 1'b1, 4'b0010, '0, 1'b1);
    do_cycle(1'b0, 1'b1, 4'b0000, '0, 1'b1);
    check_eq("t4_err", 32'(err_a), 32'd1);
    check_eq("t4_busy", 32'(busy_a), 32'd0);
    for (int j = 0; j < 5; j++) begin
      do_cycle(1'b0, 1'b1, '0, '0, 1'b1);
      check_eq("t4_err_sticky", 32'(err_a), 32'd1);
      check_eq("t4_no_gnt", 32'(gnt_a), 32'd0);
    end

    // All four requesting continuously: rotation 0,1,2,3,0 at DELAY+2 spacing.
    do_cycle(1'b1, 1'b1, '0, '0, 1'b1);
    check_eq("t2_err_cleared", 32'(err_a), 32'd0);
    p_raise = 100;
    p_drop  = 0;
    do_cycle(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
    for (int j = 0; j < 22; j++) begin
      do_cycle(1'b0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < N; i++) begin
        if (gnt_a[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
    end
    check_eq("t2_grant_count", 32'(g_idx.size() >= 5), 32'd1);
    if (g_idx.size() >= 5) begin
      for (int j = 0; j < 5; j++) begin
        check_eq($sformatf("t2_order%0d", j), 32'(g_idx[j]), 32'(exp_order[j]));
        if (j > 0) check_eq($sformatf("t2_space%0d", j), 32'(g_cyc[j] - g_cyc[j-1]), 32'd4);
      end
    end

    // DELAY=0 instance: immediate grant, then pointer wrap 3 -> 0 -> 1.
    do_cycle(1'b1, 1'b1, '0, '0, 1'b1);
    do_cycle(1'b0, 1'b1, '0, 4'b0100, 1'b1);
    check_eq("t6_gnt", 32'(gnt_b), 32'b0100);
    check_eq("t6_busy", 32'(busy_b), 32'd1);
    do_cycle(1'b0, 1'b1, '0, 4'b0100, 1'b1);
    check_eq("t6_gnt_end", 32'(gnt_b), 32'd0);
    check_eq("t6_busy_end", 32'(busy_b), 32'd0);
    do_cycle(1'b0, 1'b1, '0, 4'b1001, 1'b1);
    check_eq("t3_first", 32'(gnt_b), 32'b1000);
    do_cycle(1'b0, 1'b1, '0, 4'b1001, 1'b1);
    check_eq("t3_gap", 32'(gnt_b), 32'd0);
    do_cycle(1'b0, 1'b1, '0, 4'b0001, 1'b1);
    check_eq("t3_second", 32'(gnt_b), 32'b0001);
    do_cycle(1'b0, 1'b1, '0, 4'b0001, 1'b1);
    do_cycle(1'b0, 1'b1, '0, 4'b0000, 1'b1);
    do_cycle(1'b0, 1'b1, '0, 4'b0011, 1'b1);
    check_eq("t3_ptr1", 32'(gnt_b), 32'b0010);
    do_cycle(1'b0, 1'b1, '0, 4'b0011, 1'b1);
    do_cycle(1'b0, 1'b1, '0, 4'b0000, 1'b1);

    // Random traffic with occasional early drops and resets.
    p_raise = 30;
    p_drop  = 3;
    for (int j = 0; j < 3000; j++) begin
      do_cycle($urandom_range(249) == 0, 1'b0, '0, '0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
